// File: rtl/return_address_stack_pkg.sv
// Shared constants and operation decode for the MIPS return address stack.
// Imported by ras_pointer and return_address_stack.
package mips_ras_pkg;

  localparam logic [4:0] RA_REG            = 5'd31;
  localparam int         RAS_DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    PUSH    = 2'b01,
    POP     = 2'b10,
    REPLACE = 2'b11
  } ras_op_t;

  // A simultaneous push/pop on an empty stack has no top to replace, so it degrades to a push.
  function automatic ras_op_t decode_op(input logic push, input logic pop, input logic empty);
    ras_op_t op;
    op = NONE;
    if (push && pop)  op = empty ? PUSH : REPLACE;
    else if (push)    op = PUSH;
    else if (pop)     op = POP;
    return op;
  endfunction

endpackage

// File: rtl/ras_pointer.sv
// Top-of-stack pointer, occupancy count and sticky underflow for the return address stack.
// Also tells the storage array where (and whether) to write this cycle.
module ras_pointer
  import mips_ras_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [PTR_W-1:0] tos,
  output logic [PTR_W:0]   count,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic             pop_ok,
  output logic             full,
  output logic             top_valid,
  output logic             underflow
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] tos_reg, tos_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             underflow_reg, underflow_next;
  logic [PTR_W-1:0] tos_inc, tos_dec;
  logic             empty;
  ras_op_t          op;

  assign empty   = (count_reg == '0);
  assign tos_inc = tos_reg + PTR_W'(1);
  assign tos_dec = tos_reg - PTR_W'(1);
  assign op      = decode_op(push, pop, empty);

  always_comb begin
    tos_next       = tos_reg;
    count_next     = count_reg;
    underflow_next = underflow_reg;
    wr_en          = 1'b0;
    wr_ptr         = tos_inc;
    if (flush) begin
      tos_next       = '0;
      count_next     = '0;
      underflow_next = 1'b0;
    end else begin
      case (op)
        PUSH: begin
          // When full the increment lands on the oldest entry, which is simply overwritten.
          tos_next   = tos_inc;
          count_next = (count_reg == DEPTH_CNT) ? count_reg : count_reg + (PTR_W + 1)'(1);
          wr_en      = 1'b1;
          wr_ptr     = tos_inc;
        end
        POP: begin
          if (empty) begin
            underflow_next = 1'b1;
          end else begin
            tos_next   = tos_dec;
            count_next = count_reg - (PTR_W + 1)'(1);
          end
        end
        REPLACE: begin
          wr_en  = 1'b1;
          wr_ptr = tos_reg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tos_reg       <= '0;
      count_reg     <= '0;
      underflow_reg <= 1'b0;
    end else begin
      tos_reg       <= tos_next;
      count_reg     <= count_next;
      underflow_reg <= underflow_next;
    end
  end

  assign tos       = tos_reg;
  assign count     = count_reg;
  assign pop_ok    = pop && !flush && !empty;
  assign full      = (count_reg == DEPTH_CNT);
  assign top_valid = !empty;
  assign underflow = underflow_reg;

endmodule

// File: rtl/return_address_stack.sv
// Return address stack: JAL pushes the link value, JR $31 pops the predicted target.
// Define RAS_VERIFY_EN to add jr_target / mispredict_cnt prediction checking.
module return_address_stack
  import mips_ras_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH_DEFAULT,
  parameter int ADDR_W = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  input  logic              flush,
  output logic [ADDR_W-1:0] top_addr,
  output logic              top_valid,
  output logic              full,
  output logic              underflow
`ifdef RAS_VERIFY_EN
  ,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [15:0]       mispredict_cnt
`endif
);

  logic [PTR_W-1:0]  tos;
  logic [PTR_W:0]    count;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_ptr;
  logic              pop_ok;
  logic [ADDR_W-1:0] mem [DEPTH];

  ras_pointer #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .tos       (tos),
    .count     (count),
    .wr_en     (wr_en),
    .wr_ptr    (wr_ptr),
    .pop_ok    (pop_ok),
    .full      (full),
    .top_valid (top_valid),
    .underflow (underflow)
  );

  // Storage is never cleared; emptiness is tracked by count alone.
  always_ff @(posedge clock) begin
    if (reset_n && wr_en) mem[wr_ptr] <= push_addr;
  end

  assign top_addr = top_valid ? mem[tos] : '0;

`ifdef RAS_VERIFY_EN
  logic [15:0] mispredict_cnt_reg;

  // Cleared by reset only, so the count survives context-switch flushes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mispredict_cnt_reg <= '0;
    end else if (pop_ok && (top_addr != jr_target) && (mispredict_cnt_reg != 16'hFFFF)) begin
      mispredict_cnt_reg <= mispredict_cnt_reg + 16'd1;
    end
  end

  assign mispredict_cnt = mispredict_cnt_reg;
`else
  logic unused_pop_ok;
  logic [4:0] unused_ra_reg;
  assign unused_pop_ok = pop_ok;
  assign unused_ra_reg = RA_REG;
`endif

endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
- Hardware stack of link addresses, the read-side counterpart of the JAL write to $31.
- JAL pushes PC+4 (the value written to register 31).
- JR $31 pops it, giving the predicted return target to the fetch stage one cycle ahead of the register-file read.
- Sits beside the register file and the PC-select mux; drives the `ra_pred` input of the next-PC logic.

Parameters:
- DEPTH, 8, number of stack entries; power of 2, minimum 2.
- ADDR_W, 32, width of a stored return address.
- PTR_W, $clog2(DEPTH), width of the top-of-stack pointer.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- push  input  1  JAL/JALR with destination 31 retiring this cycle.
- push_addr  input  ADDR_W  link value (PC+4) to store.
- pop  input  1  JR with rs == 31 retiring this cycle.
- flush  input  1  discard all entries (exception / context switch).
- top_addr  output  ADDR_W  current top entry; combinational from registered state.
- top_valid  output  1  stack non-empty.
- full  output  1  count == DEPTH.
- underflow  output  1  sticky; set by a pop while empty; cleared only by flush or reset.

Behaviour:
- Reset: asynchronous, while reset_n=0. Clears tos pointer to 0, count to 0 and underflow to 0. Storage is not cleared. Outputs: top_valid=0, full=0, underflow=0, top_addr=0 (forced to 0 whenever count==0).
- Storage: circular buffer `mem[DEPTH]`. `tos` points at the current top. `count` is 0..DEPTH (PTR_W+1 bits).
- Read: `top_addr = mem[tos]` when count>0, else 0. Zero-cycle read. Writes become visible the cycle after the edge.
- Push only: `tos <= tos+1` (mod DEPTH), `mem[tos+1] <= push_addr`, `count <= min(count+1, DEPTH)`.
  - Push when full: overwrites the oldest entry (wrap-around). count stays DEPTH; no error flag.
- Pop only, count>0: `tos <= tos-1` (mod DEPTH), `count <= count-1`. The popped value is `top_addr` in the same cycle.
- Pop only, count==0: pointer and count unchanged; underflow <= 1.
- Push and pop together: the top entry is replaced in place. `mem[tos] <= push_addr`, tos and count unchanged. If count==0, behaves as a plain push (count becomes 1); underflow is not set.
- Flush: highest priority. `count <= 0`, `tos <= 0`, underflow <= 0. Push and pop in the same cycle are ignored.
- No handshake stalls: every request completes in one cycle.
- Reset asserted mid-operation aborts any in-flight push; the next cycle after reset release starts empty.

Optional Feature:
- Macro: RAS_VERIFY_EN.
- When defined, two ports are added:
  - input `jr_target` [ADDR_W-1:0]: the actual $31 value from the register file.
  - output `mispredict_cnt` [15:0].
- On each pop with count>0 and `top_addr != jr_target`, the counter increments, saturating at 16'hFFFF.
- The counter is cleared by reset only, not by flush.
- When the macro is undefined: neither port exists, and no counter logic is present.

Decomposition:
- Package `mips_ras_pkg`:
  - constant `RA_REG = 5'd31`
  - constant `RAS_DEPTH_DEFAULT = 8`
  - typedef `ras_op_t` {NONE, PUSH, POP, REPLACE}, decoded from push/pop.
- One sub-module: `ras_pointer`.
  - Owns tos, count and underflow update, plus full/top_valid generation.
  - Parameterised by DEPTH.
  - The top level holds the storage array and the optional verify counter.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, release → top_valid=0, full=0, underflow=0, top_addr=0.
- Push 0x0040_0010, 0x0040_0020, then pop twice:
  - Before pops: top_addr=0x0040_0020.
  - After first pop: top_addr=0x0040_0010.
  - After second pop: top_valid=0.
- Overflow wrap, DEPTH=8:
  - Push 0x100..0x900 (9 values, step 0x100) → full=1, top_addr=0x900.
  - Then 8 pops return 0x900 down to 0x200; afterwards top_valid=0 (0x100 lost).
- Simultaneous push and pop:
  - Stack {0xA0, 0xB0 top}; push=pop=1 with push_addr=0xC0 → count stays 2, top_addr=0xC0.
  - Next pop gives top_addr=0xA0.
- Underflow and flush:
  - Pop on empty → underflow=1, sticky over 5 idle cycles.
  - flush=1 together with push=1 → underflow=0, top_valid=0 (push ignored).
- RAS_VERIFY_EN:
  - Push 0x400; pop with jr_target=0x404 → mispredict_cnt=1.
  - Push 0x500; pop with jr_target=0x500 → mispredict_cnt stays 1.
  - Asynchronous reset mid-stream → mispredict_cnt=0.
